// File: rtl/ysyx_23060184_ifu.sv
// ysyx_23060184_ifu: multicycle instruction fetch over a valid/ready memory read port
module ysyx_23060184_ifu #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000,
  parameter logic [DATA_W-1:0]  ERR_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  output logic              npc_ready,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_err
);
  typedef enum logic [2:0] {IDLE, AR, R, OUT, WNPC} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, inst_pc_q, inst_pc_d, araddr_q, araddr_d, tgt;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              pend_q, pend_d, err_q, err_d, go, npc_take;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, ivalid_q, ivalid_d, nready_q, nready_d;
  // next-state logic; a redirect (go) sends a new PC to AR, or straight to an error OUT if misaligned
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    npc_take  = npc_valid && nready_q;
    go        = 1'b0;
    tgt       = pend_q ? pend_pc_q : npc;
    case (state_q)
      IDLE: begin
        go  = 1'b1;
        tgt = pc_q;
      end
      AR: state_d = mem_arready ? R : AR;
      R: if (mem_rvalid) begin
        inst_d    = (mem_rresp == 2'd0) ? mem_rdata : ERR_INST;
        inst_pc_d = pc_q;
        err_d     = |mem_rresp;
        state_d   = OUT;
      end
      OUT: begin
        if (npc_take) begin
          pend_d    = 1'b1;
          pend_pc_d = npc;
        end
        if (inst_ready) begin
          go      = pend_q || npc_take;
          pend_d  = 1'b0;
          state_d = WNPC;
        end
      end
      WNPC: go = npc_valid;
      default: state_d = IDLE;
    endcase
    if (go) begin
      pc_d    = tgt;
      state_d = |tgt[1:0] ? OUT : AR;
      if (|tgt[1:0]) begin
        inst_d    = ERR_INST;
        inst_pc_d = tgt;
        err_d     = 1'b1;
      end
    end
    arvalid_d = state_d == AR;
    araddr_d  = (state_d == AR) ? pc_d : '0;
    rready_d  = state_d == R;
    ivalid_d  = state_d == OUT;
    nready_d  = (state_d == OUT && !pend_d) || state_d == WNPC;
  end
  // state and registered outputs; reset returns everything to a quiet fetch-from-RESET_PC start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      ivalid_q  <= 1'b0;
      nready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      ivalid_q  <= ivalid_d;
      nready_q  <= nready_d;
    end
  end
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_rready  = rready_q;
  assign inst_valid  = ivalid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_err   = err_q;
  assign npc_ready   = nready_q;
endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// tb_ysyx_23060184_ifu: randomized self-checking bench for the fetch unit
module tb_ysyx_23060184_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] ERR    = 32'h0000_0013;
  logic        clk = 1'b0, reset = 1'b1, npc_valid = 1'b0, mem_arready = 1'b0, mem_rvalid = 1'b0, inst_ready = 1'b0;
  logic [31:0] npc = '0, mem_rdata = '0;
  logic [1:0]  mem_rresp = '0;
  logic        npc_ready, mem_arvalid, mem_rready, inst_valid, fetch_err;
  logic [31:0] mem_araddr, inst, inst_pc;
  int          vectors = 0, errs = 0, ar_cnt = 0;
  logic [31:0] cur_inst, cur_pc;
  logic        cur_err;

  ysyx_23060184_ifu dut (
    .clk(clk), .reset(reset), .npc_valid(npc_valid), .npc(npc), .npc_ready(npc_ready),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rready(mem_rready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_arvalid && mem_arready) ar_cnt++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == RST_PC) ? 32'h0010_0093 : {a[15:0] ^ 16'hbeef, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out();
    chk("inst_valid", inst_valid, 1);
    chk("inst", inst, cur_inst);
    chk("inst_pc", inst_pc, cur_pc);
    chk("fetch_err", fetch_err, cur_err);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, mem_arvalid, 0);
    chk({tag, "_araddr"}, mem_araddr, 0);
    chk({tag, "_rready"}, mem_rready, 0);
    chk({tag, "_ivalid"}, inst_valid, 0);
    chk({tag, "_nready"}, npc_ready, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_instpc"}, inst_pc, 0);
    chk({tag, "_err"}, fetch_err, 0);
  endtask

  task automatic junk();
    npc_valid  = 1'($urandom_range(0, 1));
    npc        = $urandom;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
  endtask

  task automatic unjunk();
    npc_valid  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // called at the negedge right after the fetch address was accepted
  task automatic do_fetch(input logic [31:0] pc);
    int k, d, a0;
    cur_pc = pc;
    if (pc[1:0] != 2'b00) begin
      chk("misaligned_no_ar", mem_arvalid, 0);
      cur_inst = ERR;
      cur_err  = 1'b1;
    end else begin
      a0 = ar_cnt;
      k  = $urandom_range(0, 3);
      for (int i = 0; i <= k; i++) begin
        chk("ar_valid", mem_arvalid, 1);
        chk("araddr", mem_araddr, pc);
        chk("ar_nready", npc_ready, 0);
        mem_arready = (i == k);
        junk();
        step();
        mem_arready = 1'b0;
        unjunk();
      end
      d = $urandom_range(0, 5);
      for (int i = 0; i <= d; i++) begin
        chk("r_rready", mem_rready, 1);
        chk("r_arvalid", mem_arvalid, 0);
        chk("r_ivalid", inst_valid, 0);
        npc_valid = 1'($urandom_range(0, 1));
        npc       = $urandom;
        cur_err   = (pc != RST_PC) && ($urandom_range(0, 4) == 0);
        mem_rvalid = (i == d);
        mem_rdata  = mem_word(pc);
        mem_rresp  = cur_err ? 2'($urandom_range(1, 3)) : 2'b00;
        step();
        npc_valid  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rresp  = 2'($urandom);
        mem_rdata  = $urandom;
      end
      chk("ar_once", ar_cnt - a0, 1);
      cur_inst = cur_err ? ERR : mem_word(pc);
    end
    chk_out();
  endtask

  // holds the instruction a random time, then delivers next PC early or in WNPC
  task automatic handoff(input logic [31:0] nxt, input bit early);
    int h, e, w;
    h = $urandom_range(0, 4);
    e = $urandom_range(0, h);
    for (int i = 0; i <= h; i++) begin
      chk_out();
      chk("out_nready", npc_ready, (early && i > e) ? 0 : 1);
      if (early && i == e) begin
        npc_valid = 1'b1;
        npc       = nxt;
      end
      inst_ready = (i == h);
      step();
      npc_valid  = 1'b0;
      inst_ready = 1'b0;
      npc        = $urandom;
    end
    if (!early) begin
      w = $urandom_range(0, 2);
      for (int i = 0; i <= w; i++) begin
        chk("wnpc_nready", npc_ready, 1);
        chk("wnpc_ivalid", inst_valid, 0);
        chk("wnpc_arvalid", mem_arvalid, 0);
        npc_valid = (i == w);
        npc       = nxt;
        step();
        npc_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] nxt, r;
    bit          early;
    repeat (3) step();
    chk_quiet("reset");
    reset = 1'b0;
    step();
    do_fetch(RST_PC);
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      case (n)
        0: begin nxt = 32'h8000_0004; early = 1'b0; end
        1: begin nxt = 32'h8000_0004; early = 1'b1; end
        2: begin nxt = 32'h8000_0006; early = 1'b0; end
        3: begin nxt = 32'h8000_0006; early = 1'b1; end
        default: begin
          nxt   = {16'h8000, r[15:2], (r[31:29] == 3'd0) ? ((r[1:0] == 2'b00) ? 2'b10 : r[1:0]) : 2'b00};
          early = r[20];
        end
      endcase
      handoff(nxt, early);
      do_fetch(nxt);
    end
    handoff(32'h8000_0100, 1'b0);
    chk("pre_reset_ar", mem_arvalid, 1);
    mem_arready = 1'b1;
    step();
    mem_arready = 1'b0;
    chk("pre_reset_r", mem_rready, 1);
    reset = 1'b1;
    step();
    chk_quiet("mid_reset");
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdead_beef;
    step();
    mem_rvalid = 1'b0;
    chk("stale_ivalid", inst_valid, 0);
    do_fetch(RST_PC);
    handoff(32'h8000_0004, 1'b1);
    do_fetch(32'h8000_0004);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
